// File: rtl/led_timing_pkg.sv
// ---------------------------------------------------------------------------
// led_timing_pkg : state encoding and default WS2812-style timing constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package led_timing_pkg;

  typedef enum logic [1:0] {
    ST_LATCH = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BIT   = 2'd2
  } led_state_e;

  localparam int T0H_DEFAULT    = 40;
  localparam int T1H_DEFAULT    = 80;
  localparam int TBIT_DEFAULT   = 125;
  localparam int TLATCH_DEFAULT = 5000;
  localparam int BITS_PER_LED   = 24;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_bit_timer.sv
// ---------------------------------------------------------------------------
// led_bit_timer : per-bit cycle counter, end-of-bit flag and high/low compare
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_bit_timer
  import led_timing_pkg::*;
#(
  parameter int T0H  = T0H_DEFAULT,
  parameter int T1H  = T1H_DEFAULT,
  parameter int TBIT = TBIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic current_bit,
  output logic end_of_bit,
  output logic level
);

  localparam int CW = cnt_width(TBIT);

  logic [CW-1:0] r_count;
  logic [CW:0]   w_high_time;

  // Held at zero outside a bit so every bit starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!run || end_of_bit) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign w_high_time = current_bit ? (CW+1)'(T1H) : (CW+1)'(T0H);
  assign end_of_bit  = run && (r_count == CW'(TBIT - 1));
  assign level       = run && ({1'b0, r_count} < w_high_time);

endmodule

`default_nettype wire

// File: rtl/led_bit_sequencer.sv
// ---------------------------------------------------------------------------
// led_bit_sequencer : frame sequencer driving a serial RGB LED chain
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_bit_sequencer
  import led_timing_pkg::*;
#(
  parameter int T0H     = T0H_DEFAULT,
  parameter int T1H     = T1H_DEFAULT,
  parameter int TBIT    = TBIT_DEFAULT,
  parameter int TLATCH  = TLATCH_DEFAULT,
  parameter int NUMLEDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Enable,
  input  logic        CurrentBit,
  output logic        LoadRegister,
  output logic        RotateRegisterLeft,
  output logic [11:0] LEDCount,
  output logic        DataOut,
  output logic        FrameDone
);

  localparam int LCW = cnt_width(TLATCH);
  localparam int LW  = cnt_width(NUMLEDS);

  localparam logic [LCW-1:0] LAST_LATCH = LCW'(TLATCH - 1);
  localparam logic [LW-1:0]  LAST_LED   = LW'(NUMLEDS - 1);
  localparam logic [4:0]     LAST_BIT   = 5'(BITS_PER_LED - 1);

  led_state_e     r_state;
  led_state_e     w_state_next;
  logic [LCW-1:0] r_latch_cnt;
  logic [4:0]     r_bit_idx;
  logic [4:0]     w_bit_next;
  logic [LW-1:0]  r_led_count;
  logic [LW-1:0]  w_led_next;
  logic           r_data_out;
  logic           w_end_of_bit;
  logic           w_level;

  led_bit_timer #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_bit_timer (
    .clk         (clk),
    .rst_n       (reset),
    .run         (r_state == ST_BIT),
    .current_bit (CurrentBit),
    .end_of_bit  (w_end_of_bit),
    .level       (w_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_LATCH;
      r_bit_idx   <= '0;
      r_led_count <= '0;
      r_data_out  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_idx   <= w_bit_next;
      r_led_count <= w_led_next;
      r_data_out  <= w_level;
    end
  end

  // Saturates at the last count so a late Enable starts LOAD on the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_latch_cnt <= '0;
    end else if (r_state != ST_LATCH) begin
      r_latch_cnt <= '0;
    end else if (r_latch_cnt != LAST_LATCH) begin
      r_latch_cnt <= r_latch_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_bit_next         = r_bit_idx;
    w_led_next         = r_led_count;
    LoadRegister       = 1'b0;
    RotateRegisterLeft = 1'b0;
    FrameDone          = 1'b0;
    case (r_state)
      ST_LATCH: begin
        if ((r_latch_cnt == LAST_LATCH) && Enable) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        LoadRegister = 1'b1;
        w_led_next   = '0;
        w_bit_next   = '0;
        w_state_next = ST_BIT;
      end
      ST_BIT: begin
        if (w_end_of_bit) begin
          if (r_bit_idx != LAST_BIT) begin
            RotateRegisterLeft = 1'b1;
            w_bit_next         = r_bit_idx + 1'b1;
          end else if (r_led_count != LAST_LED) begin
            // Next colour loads back-to-back with no gap cycle.
            LoadRegister = 1'b1;
            w_led_next   = r_led_count + 1'b1;
            w_bit_next   = '0;
          end else begin
            FrameDone    = 1'b1;
            w_led_next   = '0;
            w_bit_next   = '0;
            w_state_next = ST_LATCH;
          end
        end
      end
      default: begin
        w_state_next = ST_LATCH;
      end
    endcase
  end

  // The shift register samples LEDCount on the load edge, so expose the new index.
  assign LEDCount = 12'(LoadRegister ? w_led_next : r_led_count);
  assign DataOut  = r_data_out;

endmodule

`default_nettype wire
